ram_access_arbiter: RTL and testbench
=====================================

# ram_access_arbiter

Shares one simple dual-port RAM between two requesters, A and B, using round-robin arbitration. It also provides a built-in clear engine that zero-fills the whole RAM. The block sits between the game-logic FSMs (for example, the guess-history writer and the display scanner) and a single RAM instance, and drives that RAM's write and read ports. One transaction is served per cycle, so reads and writes are never issued to the RAM in the same cycle.

## Interface
Parameters:
- SIZE, 8, word width of the RAM and of the client data buses
- DEPTH, 8, number of RAM entries; AW = $clog2(DEPTH)

Ports:
- clk  in  1  single clock; the RAM uses it for both wclk and rclk
- rst  in  1  reset, synchronous, active-high
- clear  in  1  pulse to start the zero-fill sweep
- busy  out  1  high while the sweep runs
- a_req, b_req  in  1  transaction request; held until granted
- a_write, b_write  in  1  1 = write, 0 = read
- a_addr, b_addr  in  AW  transaction address
- a_wdata, b_wdata  in  SIZE  write data
- a_gnt, b_gnt  out  1  combinational grant; the transaction executes in this cycle
- a_rvalid, b_rvalid  out  1  read data valid for that client
- rdata  out  SIZE  read data; a direct pass-through of ram_read_data
- ram_waddr  out  AW  to the RAM waddr port
- ram_write_data  out  SIZE  to the RAM write_data port
- ram_write_en  out  1  to the RAM write_en port
- ram_raddr  out  AW  to the RAM raddr port
- ram_read_data  in  SIZE  from the RAM read_data port

## Operation
- States are IDLE and CLEAR. State is a register; reset enters IDLE.
- Round-robin pointer `last`: 0 = A was served last, 1 = B was served last. Reset value is 1, so A wins the first contention.
- IDLE with clear=0:
  - One requester active: that requester is granted.
  - Both active: the client not equal to `last` is granted. `last` updates to the granted client.
- Grant effects:
  - Granted write: ram_write_en=1, ram_waddr=addr, ram_write_data=wdata.
  - Granted read: ram_raddr=addr, ram_write_en=0.
- Read return: the registered owner tag asserts a_rvalid or b_rvalid for exactly one cycle, in the cycle after the read grant.
- IDLE with clear=1:
  - No grant is issued in that cycle, even if requests are present.
  - The sweep counter loads 0 and the next state is CLEAR.
- CLEAR:
  - Each cycle: ram_write_en=1, ram_waddr=counter, ram_write_data=0; the counter increments.
  - The cycle with counter = DEPTH-1 is the last write, after which the state returns to IDLE.
  - No grants are issued in CLEAR.
  - clear asserted during CLEAR is ignored; the sweep does not restart.
- When idle, ram_raddr, ram_waddr and ram_write_data hold 0. The RAM read port may still return data, but no rvalid is asserted.
- The sweep counter is AW+1 bits wide, so DEPTH being a power of two does not cause wrap-around ambiguity.
- Write-then-read of the same address from consecutive grants returns the new data. The write commits at edge N and the read is registered at edge N+1.

## Timing
- Reset (rst=1 at an edge): state=IDLE, last=1, counter=0, rvalid tags=0.
- While rst=1, all grants, ram_write_en and busy are forced to 0.
- Outputs after reset: busy=0, a_gnt=b_gnt=0, a_rvalid=b_rvalid=0, ram_write_en=0.
- Grant latency: 0 cycles. gnt is asserted combinationally in the cycle req is high, subject to arbitration.
- Read latency: rvalid and rdata are valid 1 cycle after gnt.
- busy timing:
  - High from the cycle after clear is sampled through the last sweep write, for exactly DEPTH cycles.
  - Low in the cycle the state returns to IDLE, and grants may resume in that same cycle.
- Throughput: 1 transaction per cycle in IDLE. Under continuous contention, A and B alternate every cycle.
- Reset during CLEAR: the sweep aborts at that edge. Entries not yet written keep their old contents, and busy=0 on the next cycle.
- Reset in the cycle after a read grant: the pending rvalid is suppressed.

## Test plan
- Reset, then A writes 0x5A to address 3. A reads address 3 on the next cycle; a_gnt=1 in both cycles, a_rvalid=1 one cycle after the read, rdata=0x5A, b_rvalid=0.
- A and B both read continuously for 6 cycles: grants follow A,B,A,B,A,B; each rvalid follows its own grant by 1 cycle.
- With DEPTH=8, write 0xFF to all addresses, then pulse clear: busy is high for exactly 8 cycles and ram_waddr steps 0..7 with data 0. Reading all 8 afterwards returns 0x00.
- clear and a_req are asserted in the same IDLE cycle: a_gnt=0 in that cycle and throughout the sweep. a_gnt=1 in the first cycle with busy=0.
- rst asserted at sweep address 4 (DEPTH=8, RAM pre-filled with 0xFF): busy=0 the next cycle; addresses 0-3 read 0x00 and addresses 4-7 read 0xFF.
- B issues a read and rst is asserted the following cycle: b_rvalid stays 0. After release, the first contention grants A.

Source files
------------

// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between the two RAM clients, the clear control and the RAM
// ports. The arbiter uses the slave view; clients and the RAM use master.
interface ram_access_arbiter_if #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic            clear;
  logic            busy;

  logic            a_req;
  logic            a_write;
  logic [AW-1:0]   a_addr;
  logic [SIZE-1:0] a_wdata;
  logic            a_gnt;
  logic            a_rvalid;

  logic            b_req;
  logic            b_write;
  logic [AW-1:0]   b_addr;
  logic [SIZE-1:0] b_wdata;
  logic            b_gnt;
  logic            b_rvalid;

  logic [SIZE-1:0] rdata;

  logic [AW-1:0]   ram_waddr;
  logic [SIZE-1:0] ram_write_data;
  logic            ram_write_en;
  logic [AW-1:0]   ram_raddr;
  logic [SIZE-1:0] ram_read_data;

  modport slave (
    input  clear,
    output busy,
    input  a_req, a_write, a_addr, a_wdata,
    output a_gnt, a_rvalid,
    input  b_req, b_write, b_addr, b_wdata,
    output b_gnt, b_rvalid,
    output rdata,
    output ram_waddr, ram_write_data, ram_write_en, ram_raddr,
    input  ram_read_data
  );

  modport master (
    output clear,
    input  busy,
    output a_req, a_write, a_addr, a_wdata,
    input  a_gnt, a_rvalid,
    output b_req, b_write, b_addr, b_wdata,
    input  b_gnt, b_rvalid,
    input  rdata,
    input  ram_waddr, ram_write_data, ram_write_en, ram_raddr,
    output ram_read_data
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one simple dual-port RAM between clients A
// and B, with a built-in sweep that zero-fills every RAM entry.
module ram_access_arbiter #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_access_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  // Sweep counter carries one extra bit so a power-of-two DEPTH never aliases
  localparam logic [AW:0] LAST_ADDR = (AW + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      r_state;
  logic        r_last;
  logic [AW:0] r_sweepCount;
  logic        r_aRvalid;
  logic        r_bRvalid;

  logic        w_serve;
  logic        w_aGnt;
  logic        w_bGnt;

  // A cycle only serves a client when idle, not starting a sweep, and not in reset
  assign w_serve = (r_state == IDLE) && !bus.clear && !rst;
  assign w_aGnt  = w_serve && bus.a_req && (!bus.b_req || r_last);
  assign w_bGnt  = w_serve && bus.b_req && (!bus.a_req || !r_last);

  assign bus.a_gnt    = w_aGnt;
  assign bus.b_gnt    = w_bGnt;
  assign bus.a_rvalid = r_aRvalid && !rst;
  assign bus.b_rvalid = r_bRvalid && !rst;
  assign bus.busy     = (r_state == CLEAR) && !rst;
  assign bus.rdata    = bus.ram_read_data;

  // Steer the RAM ports from the sweep or the granted client; idle ports rest at zero
  always_comb begin
    bus.ram_write_en   = 1'b0;
    bus.ram_waddr      = '0;
    bus.ram_write_data = '0;
    bus.ram_raddr      = '0;
    if ((r_state == CLEAR) && !rst) begin
      bus.ram_write_en = 1'b1;
      bus.ram_waddr    = r_sweepCount[AW-1:0];
    end else if (w_aGnt) begin
      if (bus.a_write) begin
        bus.ram_write_en   = 1'b1;
        bus.ram_waddr      = bus.a_addr;
        bus.ram_write_data = bus.a_wdata;
      end else begin
        bus.ram_raddr = bus.a_addr;
      end
    end else if (w_bGnt) begin
      if (bus.b_write) begin
        bus.ram_write_en   = 1'b1;
        bus.ram_waddr      = bus.b_addr;
        bus.ram_write_data = bus.b_wdata;
      end else begin
        bus.ram_raddr = bus.b_addr;
      end
    end
  end

  // State, round-robin pointer, sweep counter and read-owner tags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last       <= 1'b1;
      r_sweepCount <= '0;
      r_aRvalid    <= 1'b0;
      r_bRvalid    <= 1'b0;
    end else begin
      r_aRvalid <= w_aGnt && !bus.a_write;
      r_bRvalid <= w_bGnt && !bus.b_write;
      if (w_aGnt) begin
        r_last <= 1'b0;
      end else if (w_bGnt) begin
        r_last <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (bus.clear) begin
            r_sweepCount <= '0;
            r_state      <= CLEAR;
          end
        end
        CLEAR: begin
          r_sweepCount <= r_sweepCount + 1'b1;
          if (r_sweepCount == LAST_ADDR) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: cycle vectors plus hand-written
// sequences for the clear sweep and reset corner cases.
module tb_ram_access_arbiter;
  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  ram_access_arbiter_if #(.SIZE(8), .DEPTH(8)) bus ();

  ram_access_arbiter #(.SIZE(8), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: synchronous write and registered read on the same clock
  logic [7:0] mem [0:7];
  always @(posedge clk) begin
    if (bus.ram_write_en) mem[bus.ram_waddr] <= bus.ram_write_data;
    bus.ram_read_data <= mem[bus.ram_raddr];
  end

  typedef struct {
    int r, c, aq, aw, aa, ad, bq, bw, ba, bd;
    logic [19:0] expOut;
    int chk;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input int r, input int c,
                        input int aq, input int aw, input int aa, input int ad,
                        input int bq, input int bw, input int ba, input int bd,
                        input int ag, input int bg, input int av, input int bv,
                        input int bs, input int we, input int wa, input int wd,
                        input int ra, input int ck, input int er);
    vec_t v;
    v.r = r; v.c = c; v.aq = aq; v.aw = aw; v.aa = aa; v.ad = ad;
    v.bq = bq; v.bw = bw; v.ba = ba; v.bd = bd;
    v.expOut = {ag[0], bg[0], av[0], bv[0], bs[0], we[0], 3'(wa), 8'(wd), 3'(ra)};
    v.chk = ck;
    v.expRdata = 8'(er);
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input int r, input int c,
                               input int aq, input int aw, input int aa, input int ad,
                               input int bq, input int bw, input int ba, input int bd);
    @(posedge clk);
    #1;
    rst         = r[0];
    bus.clear   = c[0];
    bus.a_req   = aq[0];
    bus.a_write = aw[0];
    bus.a_addr  = 3'(aa);
    bus.a_wdata = 8'(ad);
    bus.b_req   = bq[0];
    bus.b_write = bw[0];
    bus.b_addr  = 3'(ba);
    bus.b_wdata = 8'(bd);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] packedOutputs();
    return {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.busy,
            bus.ram_write_en, bus.ram_waddr, bus.ram_write_data, bus.ram_raddr};
  endfunction

  task automatic fillAll(input int value);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1, 1, i, value, 0, 0, 0, 0);
      checkOutput($sformatf("fill%0d a_gnt", i), 32'(bus.a_gnt), 32'd1);
    end
  endtask

  task automatic readAll(input string tag, input int splitAddr, input int lowVal, input int highVal);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) applyStimulus(0, 0, 1, 0, i, 0, 0, 0, 0, 0);
      else       applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (i > 0) begin
        checkOutput($sformatf("%s rvalid%0d", tag, i - 1), 32'(bus.a_rvalid), 32'd1);
        checkOutput($sformatf("%s rdata%0d", tag, i - 1), 32'(bus.rdata),
                    ((i - 1) < splitAddr) ? 32'(lowVal) : 32'(highVal));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.a_req = 1'b0; bus.a_write = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_write = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

    //     r c  aq aw aa ad    bq bw ba bd    ag bg av bv bs we wa wd    ra ck er
    addVec(1,0, 1, 1, 3,'h5A, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0);
    addVec(1,0, 0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0);
    addVec(0,0, 1, 1, 3,'h5A, 0, 0, 0, 0,    1, 0, 0, 0, 0, 1, 3,'h5A,  0, 0, 0);
    addVec(0,0, 1, 0, 3, 0,   0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0,    3, 0, 0);
    addVec(0,0, 0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 0,    0, 1,'h5A);
    addVec(0,0, 0, 0, 0, 0,   1, 1, 5,'hC3,  0, 1, 0, 0, 0, 1, 5,'hC3,  0, 0, 0);
    addVec(0,0, 1, 0, 3, 0,   1, 0, 5, 0,    1, 0, 0, 0, 0, 0, 0, 0,    3, 0, 0);
    addVec(0,0, 1, 0, 3, 0,   1, 0, 5, 0,    0, 1, 1, 0, 0, 0, 0, 0,    5, 1,'h5A);
    addVec(0,0, 1, 0, 3, 0,   1, 0, 5, 0,    1, 0, 0, 1, 0, 0, 0, 0,    3, 1,'hC3);
    addVec(0,0, 1, 0, 3, 0,   1, 0, 5, 0,    0, 1, 1, 0, 0, 0, 0, 0,    5, 1,'h5A);
    addVec(0,0, 1, 0, 3, 0,   1, 0, 5, 0,    1, 0, 0, 1, 0, 0, 0, 0,    3, 1,'hC3);
    addVec(0,0, 1, 0, 3, 0,   1, 0, 5, 0,    0, 1, 1, 0, 0, 0, 0, 0,    5, 1,'h5A);
    addVec(0,0, 0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 0, 1, 0, 0, 0, 0,    0, 1,'hC3);
    addVec(0,0, 0, 0, 0, 0,   1, 1, 1,'h77,  0, 1, 0, 0, 0, 1, 1,'h77,  0, 0, 0);
    addVec(0,0, 1, 0, 1, 0,   0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0,    1, 0, 0);
    addVec(0,0, 0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 0,    0, 1,'h77);
    addVec(0,0, 1, 1, 2,'hAA, 1, 1, 6,'hBB,  0, 1, 0, 0, 0, 1, 6,'hBB,  0, 0, 0);
    addVec(0,0, 1, 1, 2,'hAA, 1, 1, 6,'hBB,  1, 0, 0, 0, 0, 1, 2,'hAA,  0, 0, 0);
    addVec(0,0, 1, 0, 2, 0,   1, 0, 6, 0,    0, 1, 0, 0, 0, 0, 0, 0,    6, 0, 0);
    addVec(0,0, 1, 0, 2, 0,   0, 0, 0, 0,    1, 0, 0, 1, 0, 0, 0, 0,    2, 1,'hBB);
    addVec(0,0, 0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 0,    0, 1,'hAA);
    addVec(1,0, 1, 0, 2, 0,   1, 0, 6, 0,    0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0);
    addVec(0,0, 1, 0, 2, 0,   1, 0, 6, 0,    1, 0, 0, 0, 0, 0, 0, 0,    2, 0, 0);
    addVec(0,0, 0, 0, 0, 0,   0, 0, 0, 0,    0, 0, 1, 0, 0, 0, 0, 0,    0, 1,'hAA);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].c, vecs[i].aq, vecs[i].aw, vecs[i].aa, vecs[i].ad,
                    vecs[i].bq, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      checkOutput($sformatf("vec%0d outputs", i), 32'(packedOutputs()), 32'(vecs[i].expOut));
      if (vecs[i].chk != 0)
        checkOutput($sformatf("vec%0d rdata", i), 32'(bus.rdata), 32'(vecs[i].expRdata));
    end

    // Full sweep with A requesting throughout; a second clear mid-sweep is ignored
    fillAll('hFF);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("clearcyc a_gnt", 32'(bus.a_gnt), 32'd0);
    checkOutput("clearcyc busy", 32'(bus.busy), 32'd0);
    checkOutput("clearcyc wen", 32'(bus.ram_write_en), 32'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, (k == 3) ? 1 : 0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("sweep%0d busy", k), 32'(bus.busy), 32'd1);
      checkOutput($sformatf("sweep%0d a_gnt", k), 32'(bus.a_gnt), 32'd0);
      checkOutput($sformatf("sweep%0d wen", k), 32'(bus.ram_write_en), 32'd1);
      checkOutput($sformatf("sweep%0d waddr", k), 32'(bus.ram_waddr), 32'(k));
      checkOutput($sformatf("sweep%0d wdata", k), 32'(bus.ram_write_data), 32'd0);
    end
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("postsweep busy", 32'(bus.busy), 32'd0);
    checkOutput("postsweep a_gnt", 32'(bus.a_gnt), 32'd1);
    checkOutput("postsweep raddr", 32'(bus.ram_raddr), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("postsweep rvalid", 32'(bus.a_rvalid), 32'd1);
    checkOutput("postsweep rdata", 32'(bus.rdata), 32'd0);
    readAll("cleared", 8, 0, 0);

    // Reset lands on sweep address 4: upper half keeps its old contents
    fillAll('hFF);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("abort%0d busy", k), 32'(bus.busy), 32'd1);
      checkOutput($sformatf("abort%0d waddr", k), 32'(bus.ram_waddr), 32'(k));
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("abortrst busy", 32'(bus.busy), 32'd0);
    checkOutput("abortrst wen", 32'(bus.ram_write_en), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("abortpost busy", 32'(bus.busy), 32'd0);
    checkOutput("abortpost wen", 32'(bus.ram_write_en), 32'd0);
    readAll("partial", 4, 0, 'hFF);

    // Reset right after a B read suppresses its rvalid
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 6, 0);
    checkOutput("bread b_gnt", 32'(bus.b_gnt), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bread rst b_rvalid", 32'(bus.b_rvalid), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("bread post b_rvalid", 32'(bus.b_rvalid), 32'd0);

    // Leave A as last served, then reset must hand the next contention to A
    applyStimulus(0, 0, 1, 1, 0, 'h12, 0, 0, 0, 0);
    checkOutput("prerst a_gnt", 32'(bus.a_gnt), 32'd1);
    applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 6, 0);
    checkOutput("inrst gnts", 32'({bus.a_gnt, bus.b_gnt}), 32'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 6, 0);
    checkOutput("afterrst gnts", 32'({bus.a_gnt, bus.b_gnt}), 32'b10);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("afterrst a_rvalid", 32'(bus.a_rvalid), 32'd1);
    checkOutput("afterrst rdata", 32'(bus.rdata), 32'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
